serial_pattern_gen: RTL and testbench
=====================================

Name: serial_pattern_gen

Overview:
- Serial bit-pattern transmitter. The stimulus/driving end for the team's serial sequence detectors (e.g. the "two consecutive 1s" Mealy detector).
- Loads a parallel pattern of programmable length and shifts it out MSB-first, one bit per clk, with optional repeats.
- A forced-zero gap cycle separates repeats, so a downstream detector sees a defined break between passes.
- Sits between a test/control register block and any single-bit serial input.

Parameters:
- WIDTH, 16: maximum pattern length in bits.
- LEN_W, 5: width of len. Must satisfy 2^LEN_W > WIDTH.
- CNT_W, 4: width of the repeat count.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; pattern[WIDTH-1] is sent first.
- len  input  LEN_W  number of bits per pass. Values above WIDTH are clamped to WIDTH.
- repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1.
- abort  input  1  synchronous cancel of an active transfer.
- out  output  1  serial data, registered.
- out_valid  output  1  high while out carries a pattern (or parity) bit.
- busy  output  1  high from the accepted start until the DONE cycle ends.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (asynchronous): state=IDLE; out=0, out_valid=0, busy=0, done=0; internal shift register and counters cleared.
- All outputs are registered. Whenever out_valid=0, out=0.
- States: IDLE, SHIFT, GAP, DONE, plus PARITY when the optional feature is enabled.
- IDLE, start=1 at edge E0:
  - The block captures pattern, clamped len and repeat_n.
  - If len≠0: state→SHIFT, out=pattern[WIDTH-1], out_valid=1, busy=1, all visible immediately after E0. Zero cycles of latency from the capture edge.
  - If len=0: state→DONE with busy=1 and out_valid=0. No bits are sent.
- SHIFT:
  - Each edge presents the next lower pattern bit.
  - A pass lasts exactly len cycles, i.e. bits pattern[WIDTH-1] down to pattern[WIDTH-len].
  - After the last bit: if passes remain, state→GAP; otherwise state→DONE.
- GAP: one cycle with out=0 and out_valid=0. The pass counter is decremented, the shift register is reloaded from the captured pattern, and state→SHIFT.
- DONE: one cycle with done=1, busy=1, out_valid=0. Then state→IDLE, where busy=0 and done=0.
- start is ignored in every state except IDLE, including the DONE cycle.
- Input stability: pattern, len and repeat_n are used only at capture. Changes during a transfer have no effect.
- abort=1 in any non-IDLE state: next edge goes to IDLE with out=0, out_valid=0, busy=0. done is not pulsed.
- abort in IDLE has no effect. If abort and start are both high in IDLE, abort wins and the start is dropped.
- Asynchronous reset mid-transfer: all outputs clear immediately and there is no done pulse.
- Cycle count of a full transfer, from the E0 edge to busy falling: (repeat_n+1)·len + repeat_n + 1.

Optional Feature:
- Macro: SERIAL_PATTERN_GEN_PARITY_EN.
- Defined:
  - After the last data bit of every pass, the block enters PARITY for one cycle.
  - In PARITY, out = XOR of the len bits just sent (even parity) and out_valid=1.
  - It then proceeds to GAP or DONE as normal.
  - Transfer length grows by repeat_n+1 cycles.
- Not defined: the PARITY state and its logic are absent, and SHIFT goes directly to GAP or DONE.

Test Plan:
- Reset, then pattern=16'hB000, len=4, repeat_n=0, start pulse → out=1,0,1,1 on 4 consecutive cycles with out_valid=1; done high on the 5th cycle; busy low on the 6th.
- pattern=16'hC000, len=2, repeat_n=2 → out 1,1,gap(0,valid=0),1,1,gap,1,1, then DONE; total 9 busy cycles.
- len=0, start → no out_valid; done pulses in the cycle after the start edge. len=20 (>WIDTH) → exactly 16 bits sent.
- Start pulsed again mid-transfer and during DONE → ignored; output sequence identical to the single-start run.
- abort at the 3rd bit of a len=8 pass → next cycle out_valid=0, busy=0, no done. Assert reset mid-pass → outputs zero immediately.
- With SERIAL_PATTERN_GEN_PARITY_EN: pattern=16'hB000, len=4 → out 1,0,1,1,1 (parity=1, valid=1), done on the 6th cycle.

Source files
------------

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first, with optional repeats separated by a zero gap.
// Optional even-parity bit after each pass when SERIAL_PATTERN_GEN_PARITY_EN is defined.
module serial_pattern_gen #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_DONE
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] pat_q;
    logic [WIDTH-1:0] shreg_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bits_q;
    logic [CNT_W-1:0] pass_q;
    logic             out_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [LEN_W-1:0] len_d;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    logic             par_q;
`endif

    always_comb begin
        len_d = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            shreg_q <= '0;
            len_q   <= '0;
            bits_q  <= '0;
            pass_q  <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (state_q != S_IDLE && abort) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && !abort) begin
                        pat_q  <= pattern;
                        len_q  <= len_d;
                        pass_q <= repeat_n;
                        busy_q <= 1'b1;
                        if (len_d != '0) begin
                            // First bit goes out on the capture edge itself.
                            state_q <= S_SHIFT;
                            out_q   <= pattern[WIDTH-1];
                            valid_q <= 1'b1;
                            shreg_q <= {pattern[WIDTH-2:0], 1'b0};
                            bits_q  <= len_d - LEN_W'(1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                            par_q   <= pattern[WIDTH-1];
`endif
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bits_q != '0) begin
                        out_q   <= shreg_q[WIDTH-1];
                        shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                        bits_q  <= bits_q - LEN_W'(1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                        par_q   <= par_q ^ shreg_q[WIDTH-1];
`endif
                    end else begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                        state_q <= S_PARITY;
                        out_q   <= par_q;
`else
                        out_q   <= 1'b0;
                        valid_q <= 1'b0;
                        if (pass_q != '0) begin
                            state_q <= S_GAP;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                S_PARITY: begin
                    out_q   <= 1'b0;
                    valid_q <= 1'b0;
                    if (pass_q != '0) begin
                        state_q <= S_GAP;
                    end else begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
`endif
                S_GAP: begin
                    // Restart the pass from the captured copy, not the live input.
                    state_q <= S_SHIFT;
                    pass_q  <= pass_q - CNT_W'(1);
                    out_q   <= pat_q[WIDTH-1];
                    valid_q <= 1'b1;
                    shreg_q <= {pat_q[WIDTH-2:0], 1'b0};
                    bits_q  <= len_q - LEN_W'(1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                    par_q   <= pat_q[WIDTH-1];
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    out_q   <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: per-cycle comparison against a queue-based transfer model plus literal spot checks.
module tb_serial_pattern_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [4:0]  len = '0;
    logic [3:0]  repeat_n = '0;
    logic        abort = 1'b0;
    logic        out, out_valid, busy, done;

    int checks = 0;
    int failures = 0;

    serial_pattern_gen dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
        .repeat_n(repeat_n), .abort(abort), .out(out), .out_valid(out_valid),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected outputs per cycle: {out, out_valid, busy, done}
    logic [3:0] exp_cur = 4'b0000;
    logic [3:0] exp_q[$];

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    function automatic void build(input logic [15:0] p, input int l_in, input int r);
        int  l;
        logic par;
        l = (l_in > 16) ? 16 : l_in;
        exp_q.delete();
        if (l != 0) begin
            for (int pass = 0; pass <= r; pass++) begin
                par = 1'b0;
                for (int i = 0; i < l; i++) begin
                    par = par ^ p[15-i];
                    exp_q.push_back({p[15-i], 1'b1, 1'b1, 1'b0});
                end
                if (PAR) exp_q.push_back({par, 1'b1, 1'b1, 1'b0});
                if (pass < r) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0011);
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_cur = 4'b0000;
                exp_q.delete();
            end else if (exp_cur[1]) begin
                if (abort) begin
                    exp_cur = 4'b0000;
                    exp_q.delete();
                end else if (exp_q.size() > 0) begin
                    exp_cur = exp_q.pop_front();
                end else begin
                    exp_cur = 4'b0000;
                end
            end else if (start && !abort) begin
                build(pattern, int'(len), int'(repeat_n));
                exp_cur = exp_q.pop_front();
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            chk("cycle{out,valid,busy,done}", int'({out, out_valid, busy, done}), int'(exp_cur));
        end
    end

    logic [31:0] rec_o, rec_v, rec_b, rec_d;

    task automatic go(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
        @(negedge clk);
        pattern = p; len = l; repeat_n = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Must be entered at the negedge right after the capture edge.
    task automatic record(input int n, input logic [31:0] smask);
        rec_o = '0; rec_v = '0; rec_b = '0; rec_d = '0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            rec_o[i] = out; rec_v[i] = out_valid; rec_b[i] = busy; rec_d[i] = done;
            start = smask[i];
        end
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((busy || exp_cur[1]) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        logic [31:0] c2_o, c2_v;
        int nvalid;
        repeat (2) @(negedge clk);
        chk("reset_outputs", int'({out, out_valid, busy, done}), 0);
        reset = 1'b0;
        @(negedge clk);

        // B000, len 4, single pass
        go(16'hB000, 5'd4, 4'd0);
        record(7, 32'h0);
        $display("txn directed B000 len=4 rep=0");
        chk("b000_out",   int'(rec_o), PAR ? 29 : 13);
        chk("b000_valid", int'(rec_v), PAR ? 31 : 15);
        chk("b000_done",  int'(rec_d), PAR ? 32 : 16);
        chk("b000_busy",  int'(rec_b), PAR ? 63 : 31);

        // C000, len 2, three passes with gaps
        go(16'hC000, 5'd2, 4'd2);
        record(13, 32'h0);
        $display("txn directed C000 len=2 rep=2");
        chk("c000_out",   int'(rec_o), PAR ? 819 : 219);
        chk("c000_valid", int'(rec_v), PAR ? 1911 : 219);
        chk("c000_done",  int'(rec_d), PAR ? 2048 : 256);
        chk("c000_busy_cycles", $countones(rec_b), PAR ? 12 : 9);
        c2_o = rec_o; c2_v = rec_v;

        // Same transfer with extra starts mid-transfer and during DONE
        go(16'hC000, 5'd2, 4'd2);
        record(13, PAR ? 32'h0000_0812 : 32'h0000_0112);
        $display("txn directed C000 with stray starts");
        chk("restart_out",   int'(rec_o), int'(c2_o));
        chk("restart_valid", int'(rec_v), int'(c2_v));
        chk("restart_busy_cycles", $countones(rec_b), PAR ? 12 : 9);

        // len 0: immediate done, no data
        go(16'hFFFF, 5'd0, 4'd3);
        record(3, 32'h0);
        $display("txn directed len=0");
        chk("len0_valid", int'(rec_v), 0);
        chk("len0_done",  int'(rec_d), 1);
        chk("len0_busy",  int'(rec_b), 1);

        // len 20 clamps to 16
        go(16'hA5C3, 5'd20, 4'd0);
        record(20, 32'h0);
        $display("txn directed len=20");
        chk("len20_valid_bits", $countones(rec_v), PAR ? 17 : 16);
        chk("len20_done", int'(rec_d), PAR ? 32'h20000 : 32'h10000);

        // abort while the 3rd bit is on the line
        go(16'hFFFF, 5'd8, 4'd1);
        @(negedge clk);
        @(negedge clk);
        chk("abort_third_bit_valid", int'(out_valid), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_next", int'({out_valid, busy, done}), 0);
        nvalid = 0;
        repeat (20) begin
            @(negedge clk);
            nvalid += int'(done);
        end
        chk("abort_no_done", nvalid, 0);
        $display("txn directed abort");

        // asynchronous reset mid-pass
        go(16'hFFFF, 5'd8, 4'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("async_reset_outputs", int'({out, out_valid, busy, done}), 0);
        @(negedge clk);
        reset = 1'b0;
        nvalid = 0;
        repeat (12) begin
            @(negedge clk);
            nvalid += int'(done);
        end
        chk("reset_no_done", nvalid, 0);
        $display("txn directed async reset");

        // randomized transfers with stray starts and occasional aborts
        for (int t = 0; t < 40; t++) begin
            logic [15:0] p;
            logic [4:0]  l;
            logic [3:0]  r;
            p = 16'($urandom);
            l = 5'($urandom_range(0, 20));
            r = 4'($urandom_range(0, 3));
            $display("txn %0d pat=%h len=%0d rep=%0d", t, p, l, r);
            @(negedge clk);
            pattern = p; len = l; repeat_n = r; start = 1'b1;
            abort = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            pattern = 16'($urandom); len = 5'($urandom); repeat_n = 4'($urandom);
            for (int c = 0; c < 300; c++) begin
                if (!busy && !exp_cur[1]) break;
                start = ($urandom_range(0, 7) == 0);
                abort = ($urandom_range(0, 79) == 0);
                @(negedge clk);
            end
            start = 1'b0; abort = 1'b0;
            wait_idle("random");
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
